// File: rtl/sparrow_pkg.sv
// rtl/sparrow_pkg.sv - shared types and lane helpers for the sparrow data RAM
//   mem_access_size_e : core access size encoding (2'b11 is not a legal size)
//   data_ram_state_e  : responder FSM states
//   data_ram_req_t    : one latched core request
//   misaligned / lane_strobe / lane_wdata / read_align : byte-lane helpers
package sparrow_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE      = 2'b00,
        MEM_HALF_WORD = 2'b01,
        MEM_WORD      = 2'b10
    } mem_access_size_e;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'b00,
        DRAM_WAIT = 2'b01,
        DRAM_RESP = 2'b10
    } data_ram_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } data_ram_req_t;

    // Illegal size encodings are reported as misaligned so they share the error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            MEM_BYTE:      misaligned = 1'b0;
            MEM_HALF_WORD: misaligned = lsb[0];
            MEM_WORD:      misaligned = |lsb;
            default:       misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            MEM_BYTE:      lane_strobe = 4'b0001 << lsb;
            MEM_HALF_WORD: lane_strobe = lsb[1] ? 4'b1100 : 4'b0011;
            MEM_WORD:      lane_strobe = 4'b1111;
            default:       lane_strobe = 4'b0000;
        endcase
    endfunction

    // Replicate the right-aligned write data so every candidate lane carries it;
    // the strobe then picks the lanes that actually get written.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            MEM_BYTE:      lane_wdata = {4{wdata[7:0]}};
            MEM_HALF_WORD: lane_wdata = {2{wdata[15:0]}};
            default:       lane_wdata = wdata;
        endcase
    endfunction

    function automatic logic [31:0] read_align(input logic [1:0] size, input logic [1:0] lsb,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {lsb, 3'b000};
        case (size)
            MEM_BYTE:      read_align = {24'b0, shifted[7:0]};
            MEM_HALF_WORD: read_align = {16'b0, shifted[15:0]};
            default:       read_align = shifted;
        endcase
    endfunction

endpackage

// File: rtl/sparrow_data_ram_if.sv
// rtl/sparrow_data_ram_if.sv - core data-memory port between core (master) and RAM (slave)
//   data_mem_req_i / addr_i / byte_en_i / wr_i / wr_data_i : request from the core
//   mem_ready_o / rvalid_o / err_o / rd_data_o             : response from the RAM
interface sparrow_data_ram_if;

    logic        data_mem_req_i;
    logic [31:0] data_mem_addr_i;
    logic [1:0]  data_mem_byte_en_i;
    logic        data_mem_wr_i;
    logic [31:0] data_mem_wr_data_i;
    logic        mem_ready_o;
    logic        mem_rvalid_o;
    logic        mem_err_o;
    logic [31:0] mem_rd_data_o;

    modport master (
        output data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i, data_mem_wr_i, data_mem_wr_data_i,
        input  mem_ready_o, mem_rvalid_o, mem_err_o, mem_rd_data_o
    );

    modport slave (
        input  data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i, data_mem_wr_i, data_mem_wr_data_i,
        output mem_ready_o, mem_rvalid_o, mem_err_o, mem_rd_data_o
    );

endinterface

// File: rtl/sparrow_ram_1rw.sv
// rtl/sparrow_ram_1rw.sv - DEPTH_WORDS x 32 single-port storage with byte-lane write strobe
//   clk   : clock
//   en    : access enable for this edge
//   we    : byte-lane write strobe; all-zero makes the access a read
//   addr  : word index
//   wdata : write data, already steered onto lanes
//   rdata : registered read data, updated only by read accesses
module sparrow_ram_1rw #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sparrow_data_ram.sv
// rtl/sparrow_data_ram.sv - responder for the core data-memory port with wait states and error flags
//   clk_i  : clock
//   rst_ni : synchronous reset, active low
//   bus    : sparrow_data_ram_if slave (req/addr/size/wr/wdata in; ready/rvalid/err/rd_data out)
module sparrow_data_ram
    import sparrow_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sparrow_data_ram_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    data_ram_state_e state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    data_ram_req_t   req_q, incoming, cur;
    logic            ready, accept, issue;
    logic [31:0]     offset;
    logic            out_of_range, cur_err, resp_err_q;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [31:0]     ram_rdata;

    assign ready  = (state != DRAM_WAIT);
    assign accept = bus.data_mem_req_i && ready;

    always_comb begin
        incoming.addr  = bus.data_mem_addr_i;
        incoming.size  = bus.data_mem_byte_en_i;
        incoming.wr    = bus.data_mem_wr_i;
        incoming.wdata = bus.data_mem_wr_data_i;
    end

    // The access hits storage on the edge that enters RESP. With no wait states that
    // edge is the accept edge itself, so the incoming request is used directly;
    // after waiting, the latched copy is used.
    assign cur = (state == DRAM_WAIT) ? req_q : incoming;

    // Offset wraps below BASE_ADDR; since the window is aligned and fits below 2^32,
    // a single unsigned compare covers both ends of the range.
    assign offset       = cur.addr - BASE_ADDR;
    assign out_of_range = ({1'b0, offset} >= SPAN);
    assign cur_err      = out_of_range || misaligned(cur.size, cur.addr[1:0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        case (state)
            DRAM_IDLE, DRAM_RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = DRAM_RESP;
                        issue     = 1'b1;
                    end else begin
                        state_nxt = DRAM_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    state_nxt = DRAM_IDLE;
                end
            end
            DRAM_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DRAM_RESP;
                    issue     = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = DRAM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= DRAM_IDLE;
            cnt        <= 4'd0;
            req_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_q <= incoming;
            end
            if (issue) begin
                resp_err_q <= cur_err;
            end
        end
    end

    // Gating with rst_ni drops a write whose commit edge coincides with reset.
    assign ram_en = issue && rst_ni;
    assign ram_we = (cur.wr && !cur_err) ? lane_strobe(cur.size, cur.addr[1:0]) : 4'b0000;

    sparrow_ram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk_i),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (offset[AW+1:2]),
        .wdata (lane_wdata(cur.size, cur.wdata)),
        .rdata (ram_rdata)
    );

    // In RESP, req_q still describes the access being answered.
    assign bus.mem_ready_o   = ready;
    assign bus.mem_rvalid_o  = (state == DRAM_RESP);
    assign bus.mem_err_o     = (state == DRAM_RESP) && resp_err_q;
    assign bus.mem_rd_data_o = ((state == DRAM_RESP) && !resp_err_q && !req_q.wr)
                               ? read_align(req_q.size, req_q.addr[1:0], ram_rdata)
                               : 32'h0;

endmodule

// File: tb/tb_sparrow_data_ram.sv
// tb/tb_sparrow_data_ram.sv - scoreboard bench for sparrow_data_ram (zero and three wait states)
module tb_sparrow_data_ram;

    localparam int          DEPTH = 64;
    localparam int          W0    = 0;
    localparam int          W1    = 3;
    localparam logic [31:0] B0    = 32'h0;
    localparam logic [31:0] B1    = 32'h0000_1000;

    logic clk    = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    int   cyc    = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_acc1 = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sparrow_data_ram_if b0();
    sparrow_data_ram_if b1();

    sparrow_data_ram #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .BASE_ADDR(B0)) dut0 (
        .clk_i (clk), .rst_ni (rst0_n), .bus (b0)
    );
    sparrow_data_ram #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .BASE_ADDR(B1)) dut1 (
        .clk_i (clk), .rst_ni (rst1_n), .bus (b1)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          chk_data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0_e, m1_e;
    logic [7:0] mb [2][DEPTH*4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: storage as a flat byte array addressed from the base.
    function automatic void model(input int d, input logic [31:0] a, input logic [1:0] sz,
                                  input logic w, input logic [31:0] wd, input bit commit,
                                  output logic err, output logic [31:0] data);
        longint base = (d == 0) ? longint'(B0) : longint'(B1);
        longint off  = longint'(a) - base;
        int     nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err  = (sz == 2'd3) || (off < 0) || (off >= DEPTH*4) || ((int'(a[1:0]) % nb) != 0);
        data = 32'h0;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                if (w) begin
                    if (commit) mb[d][int'(off) + i] = wd[8*i +: 8];
                end else begin
                    data[8*i +: 8] = mb[d][int'(off) + i];
                end
            end
        end
    endfunction

    task automatic set_req(input int d, input logic req, input logic [31:0] a, input logic [1:0] sz,
                           input logic w, input logic [31:0] wd);
        if (d == 0) begin
            b0.data_mem_req_i = req; b0.data_mem_addr_i = a; b0.data_mem_byte_en_i = sz;
            b0.data_mem_wr_i = w;    b0.data_mem_wr_data_i = wd;
        end else begin
            b1.data_mem_req_i = req; b1.data_mem_addr_i = a; b1.data_mem_byte_en_i = sz;
            b1.data_mem_wr_i = w;    b1.data_mem_wr_data_i = wd;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge with req dropped,
    // so an immediately following call gives a back-to-back request.
    task automatic access(input int d, input logic [31:0] a, input logic [1:0] sz, input logic w,
                          input logic [31:0] wd, input bit expect_resp, input string name);
        logic        rdy;
        int          guard;
        exp_t        e;
        logic        err;
        logic [31:0] data;
        set_req(d, 1'b1, a, sz, w, wd);
        guard = 0;
        forever begin
            @(negedge clk);
            rdy = (d == 0) ? b0.mem_ready_o : b1.mem_ready_o;
            if (rdy) break;
            guard++;
            if (guard > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: ready got 0 expected 1 within 40 cycles", name);
                set_req(d, 1'b0, a, sz, w, wd);
                return;
            end
        end
        @(posedge clk);
        #1;
        set_req(d, 1'b0, a, sz, w, wd);
        model(d, a, sz, w, wd, expect_resp, err, data);
        if (d == 1) last_acc1 = cyc;
        if (expect_resp) begin
            e.err = err; e.data = data; e.chk_data = !w; e.cyc = cyc; e.name = name;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int d, input int n);
        logic [31:0] base, a;
        logic [1:0]  sz;
        int          r, nb;
        base = (d == 0) ? B0 : B1;
        for (int k = 0; k < n; k++) begin
            sz = 2'($urandom_range(0, 3));
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            r  = int'($urandom_range(0, DEPTH*4 + 15)) - 8;
            a  = base + 32'(r);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
            access(d, a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b1, "rand");
            idle($urandom_range(0, 2));
        end
    endtask

    always @(negedge clk) begin
        if (rst0_n) begin
            check("ready0", 32'(b0.mem_ready_o), 32'd1);
            if (b0.mem_rvalid_o) begin
                if (q0.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rvalid0: got unexpected rvalid expected none");
                end else begin
                    m0_e = q0.pop_front();
                    check({m0_e.name, " err0"}, 32'(b0.mem_err_o), 32'(m0_e.err));
                    if (m0_e.chk_data) check({m0_e.name, " data0"}, b0.mem_rd_data_o, m0_e.data);
                    check({m0_e.name, " latency0"}, 32'(cyc), 32'(m0_e.cyc + W0));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst1_n) begin
            check("ready1", 32'(b1.mem_ready_o), 32'(!(cyc >= last_acc1 && cyc < last_acc1 + W1)));
            if (b1.mem_rvalid_o) begin
                if (q1.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rvalid1: got unexpected rvalid expected none");
                end else begin
                    m1_e = q1.pop_front();
                    check({m1_e.name, " err1"}, 32'(b1.mem_err_o), 32'(m1_e.err));
                    if (m1_e.chk_data) check({m1_e.name, " data1"}, b1.mem_rd_data_o, m1_e.data);
                    check({m1_e.name, " latency1"}, 32'(cyc), 32'(m1_e.cyc + W1));
                end
            end
        end
    end

    initial begin
        int c_wr;
        int guard;
        set_req(0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        idle(3);
        @(negedge clk);
        check("reset ready0",  32'(b0.mem_ready_o),  32'd1);
        check("reset rvalid0", 32'(b0.mem_rvalid_o), 32'd0);
        check("reset err0",    32'(b0.mem_err_o),    32'd0);
        check("reset rdata0",  b0.mem_rd_data_o,     32'd0);
        check("reset ready1",  32'(b1.mem_ready_o),  32'd1);
        check("reset rvalid1", 32'(b1.mem_rvalid_o), 32'd0);
        check("reset err1",    32'(b1.mem_err_o),    32'd0);
        check("reset rdata1",  b1.mem_rd_data_o,     32'd0);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) access(0, B0 + 32'(4*i), 2'd2, 1'b1, $urandom, 1'b1, "init0");
        for (int i = 0; i < DEPTH; i++) access(1, B1 + 32'(4*i), 2'd2, 1'b1, $urandom, 1'b1, "init1");
        idle(2);

        access(0, 32'h10, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b1, "t1 wr");
        idle(1);
        access(0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1, "t1 rd");
        idle(1);
        access(0, 32'h20, 2'd0, 1'b1, 32'h11, 1'b1, "t2 wb0");
        access(0, 32'h21, 2'd0, 1'b1, 32'h22, 1'b1, "t2 wb1");
        access(0, 32'h22, 2'd0, 1'b1, 32'h33, 1'b1, "t2 wb2");
        access(0, 32'h23, 2'd0, 1'b1, 32'h44, 1'b1, "t2 wb3");
        access(0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b1, "t2 rw");
        access(0, 32'h23, 2'd0, 1'b0, 32'h0, 1'b1, "t2 rb");
        access(0, 32'h22, 2'd1, 1'b0, 32'h0, 1'b1, "t3 rh");
        access(0, 32'h21, 2'd1, 1'b0, 32'h0, 1'b1, "t3 rh mis");
        access(0, 32'h40, 2'd2, 1'b1, 32'hA5A5_A5A5, 1'b1, "t5 wr");
        c_wr = cyc;
        access(0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b1, "t5 rd");
        check("t5 b2b accept", 32'(cyc), 32'(c_wr + 1));
        access(0, B0 + 32'(4*DEPTH), 2'd2, 1'b1, 32'h1234_5678, 1'b1, "t6 oob");
        access(0, B0, 2'd2, 1'b0, 32'h0, 1'b1, "t6 word0");
        access(0, 32'h13, 2'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, "bad size");
        access(0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1, "bad size chk");
        idle(2);

        access(1, B1 + 32'h8, 2'd2, 1'b0, 32'h0, 1'b1, "t4 rd");
        for (int k = 0; k < W1; k++) begin
            @(negedge clk);
            check("t4 ready low", 32'(b1.mem_ready_o), 32'd0);
        end
        @(negedge clk);
        check("t4 rvalid", 32'(b1.mem_rvalid_o), 32'd1);
        idle(1);
        access(1, B1 - 32'd4, 2'd2, 1'b1, 32'hCAFE_F00D, 1'b1, "below base");
        access(1, B1 + 32'h30, 2'd2, 1'b1, 32'h5A5A_0FF0, 1'b0, "t6 rst wr");
        rst1_n = 1'b0;
        last_acc1 = -100;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        @(negedge clk);
        check("t6 rst ready",  32'(b1.mem_ready_o),  32'd1);
        check("t6 rst rvalid", 32'(b1.mem_rvalid_o), 32'd0);
        idle(2);
        access(1, B1 + 32'h30, 2'd2, 1'b0, 32'h0, 1'b1, "t6 rst rd");
        idle(1);

        random_run(0, 250);
        random_run(1, 150);

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d/%0d responses outstanding expected 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
